// File: rtl/br_predictor.sv
// rtl/br_predictor.sv - bimodal branch predictor with 2-bit saturating counters
// Registered query port, committed-branch training port and pipeline flush.
module br_predictor #(
   parameter int         BH_TABLE_ID_WIDTH = 8,
   parameter logic [1:0] INIT_STATE        = 2'b01
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         rdy_in,
   input  logic                         valid_from_inst_fetcher,
   input  logic [BH_TABLE_ID_WIDTH-1:0] pc_from_inst_fetcher,
   input  logic                         reset_from_rob_bus,
   input  logic                         valid_from_rob_bus,
   input  logic [BH_TABLE_ID_WIDTH-1:0] pc_from_rob_bus,
   input  logic                         is_taken_from_rob_bus,
   output logic                         valid_to_inst_fetcher,
   output logic                         is_taken_to_inst_fetcher
);

   localparam int DEPTH = 1 << BH_TABLE_ID_WIDTH;

   logic [1:0] counter_table [DEPTH];
   logic [1:0] upd_cur;
   logic [1:0] upd_next;
   logic [1:0] qry_cnt;

   always_comb begin
      upd_cur  = counter_table[pc_from_rob_bus];
      upd_next = upd_cur;
      if (is_taken_from_rob_bus) begin
         if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
      end else begin
         if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
      end
      // A same-index update this cycle is forwarded so the answer reflects it.
      qry_cnt = counter_table[pc_from_inst_fetcher];
      if (valid_from_rob_bus && (pc_from_rob_bus == pc_from_inst_fetcher))
         qry_cnt = upd_next;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++) counter_table[i] <= INIT_STATE;
         valid_to_inst_fetcher    <= 1'b0;
         is_taken_to_inst_fetcher <= 1'b0;
      end else if (rdy_in) begin
         if (valid_from_rob_bus) counter_table[pc_from_rob_bus] <= upd_next;
         if (valid_from_inst_fetcher && !reset_from_rob_bus) begin
            valid_to_inst_fetcher    <= 1'b1;
            is_taken_to_inst_fetcher <= qry_cnt[1];
         end else begin
            valid_to_inst_fetcher    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_br_predictor.sv
// tb/tb_br_predictor.sv - directed self-checking bench for br_predictor
// Each scenario task drives vectors and compares against hand-computed values.
module tb_br_predictor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rdy;
   logic       q_valid;
   logic [7:0] q_pc;
   logic       flush;
   logic       u_valid;
   logic [7:0] u_pc;
   logic       u_taken;
   logic       p_valid;
   logic       p_taken;

   int n_tests = 0;
   int n_fail  = 0;

   br_predictor #(.BH_TABLE_ID_WIDTH(8), .INIT_STATE(2'b01)) dut (
      .clk_in                   (clk),
      .rst_n_in                 (rst_n),
      .rdy_in                   (rdy),
      .valid_from_inst_fetcher  (q_valid),
      .pc_from_inst_fetcher     (q_pc),
      .reset_from_rob_bus       (flush),
      .valid_from_rob_bus       (u_valid),
      .pc_from_rob_bus          (u_pc),
      .is_taken_from_rob_bus    (u_taken),
      .valid_to_inst_fetcher    (p_valid),
      .is_taken_to_inst_fetcher (p_taken)
   );

   always #5 clk = ~clk;

   // One clock: apply inputs, take the edge, return 1 time unit after it.
   task automatic step(input logic q, input logic [7:0] qpc, input logic u,
                       input logic [7:0] upc, input logic t, input logic fl);
      q_valid = q; q_pc = qpc; u_valid = u; u_pc = upc; u_taken = t; flush = fl;
      @(posedge clk);
      #1;
      q_valid = 1'b0; u_valid = 1'b0; flush = 1'b0; u_taken = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if (p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", p_valid); end
      n_tests++;
      if (p_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %b want 0", p_taken); end
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;
      step(1, 8'h05, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1) begin n_fail++; $display("FAIL q05_valid got %b want 1", p_valid); end
      n_tests++;
      if (p_taken !== 1'b0) begin n_fail++; $display("FAIL q05_taken got %b want 0", p_taken); end
      step(0, 8'h00, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b0) begin n_fail++; $display("FAIL q05_pulse got %b want 0", p_valid); end
   endtask

   task automatic test_train();
      step(0, 8'h00, 1, 8'h05, 1, 0);
      step(0, 8'h00, 1, 8'h05, 1, 0);
      step(1, 8'h05, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_taken !== 1'b1) begin n_fail++; $display("FAIL train_up got %b want 1", p_taken); end
      step(0, 8'h00, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b0 || p_taken !== 1'b1) begin
         n_fail++; $display("FAIL hold_taken got v=%b t=%b want v=0 t=1", p_valid, p_taken);
      end
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 8'h05, 1, 0);
      step(0, 8'h00, 1, 8'h05, 0, 0);
      step(1, 8'h05, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_taken !== 1'b1) begin n_fail++; $display("FAIL sat_hi_one_nt got %b want 1", p_taken); end
      step(0, 8'h00, 1, 8'h05, 0, 0);
      step(1, 8'h05, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_taken !== 1'b0) begin n_fail++; $display("FAIL sat_hi_two_nt got %b want 0", p_taken); end
   endtask

   task automatic test_saturate_low();
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 8'h10, 0, 0);
      step(0, 8'h00, 1, 8'h10, 1, 0);
      step(1, 8'h10, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b0) begin
         n_fail++; $display("FAIL sat_lo_01 got v=%b t=%b want v=1 t=0", p_valid, p_taken);
      end
      step(0, 8'h00, 1, 8'h10, 1, 0);
      step(1, 8'h10, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_taken !== 1'b1) begin n_fail++; $display("FAIL sat_lo_10 got %b want 1", p_taken); end
   endtask

   task automatic test_bypass();
      step(1, 8'h22, 1, 8'h22, 1, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b1) begin
         n_fail++; $display("FAIL bypass_same got v=%b t=%b want v=1 t=1", p_valid, p_taken);
      end
      step(1, 8'h23, 1, 8'h22, 1, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b0) begin
         n_fail++; $display("FAIL bypass_other got v=%b t=%b want v=1 t=0", p_valid, p_taken);
      end
   endtask

   task automatic test_back_to_back();
      step(1, 8'h22, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b1) begin
         n_fail++; $display("FAIL b2b_0 got v=%b t=%b want v=1 t=1", p_valid, p_taken);
      end
      step(1, 8'h05, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b0) begin
         n_fail++; $display("FAIL b2b_1 got v=%b t=%b want v=1 t=0", p_valid, p_taken);
      end
      step(1, 8'h10, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b1) begin
         n_fail++; $display("FAIL b2b_2 got v=%b t=%b want v=1 t=1", p_valid, p_taken);
      end
   endtask

   task automatic test_flush_and_rdy();
      step(1, 8'h05, 0, 8'h00, 0, 0);
      step(1, 8'h30, 1, 8'h30, 1, 1);
      n_tests++;
      if (p_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", p_valid); end
      step(1, 8'h30, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b1) begin
         n_fail++; $display("FAIL flush_update_kept got v=%b t=%b want v=1 t=1", p_valid, p_taken);
      end
      rdy = 1'b0;
      step(1, 8'h40, 1, 8'h40, 1, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b1) begin
         n_fail++; $display("FAIL rdy_hold got v=%b t=%b want v=1 t=1", p_valid, p_taken);
      end
      rdy = 1'b1;
      step(1, 8'h40, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1 || p_taken !== 1'b0) begin
         n_fail++; $display("FAIL rdy_no_update got v=%b t=%b want v=1 t=0", p_valid, p_taken);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] idx [4];
      idx[0] = 8'h05; idx[1] = 8'h10; idx[2] = 8'h22; idx[3] = 8'h30;
      step(1, 8'h30, 0, 8'h00, 0, 0);
      n_tests++;
      if (p_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b want 1", p_valid); end
      #1; rst_n = 1'b0; #1;
      n_tests++;
      if (p_valid !== 1'b0 || p_taken !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got v=%b t=%b want v=0 t=0", p_valid, p_taken);
      end
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         step(1, idx[i], 0, 8'h00, 0, 0);
         n_tests++;
         if (p_valid !== 1'b1 || p_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reinit_%02h got v=%b t=%b want v=1 t=0", idx[i], p_valid, p_taken);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; q_valid = 1'b0; q_pc = 8'h00;
      flush = 1'b0; u_valid = 1'b0; u_pc = 8'h00; u_taken = 1'b0;
      test_reset();
      test_train();
      test_saturate_low();
      test_bypass();
      test_back_to_back();
      test_flush_and_rdy();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
